// File: rtl/scmp_microcode_pak.sv
// SC/MP accumulator/status slice: shared SR bit map and DAD state type.
package scmp_microcode_pak;

    localparam int SR_CY = 7;
    localparam int SR_OV = 6;
    localparam int SR_SB = 5;
    localparam int SR_SA = 4;
    localparam int SR_IE = 3;
    localparam int SR_F2 = 2;
    localparam int SR_F0 = 0;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } dad_state_t;

endpackage

// File: rtl/scmp_bcd_digit.sv
// One BCD digit of the decimal add: binary sum, then +6 adjust above 9.
module scmp_bcd_digit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] raw;

    always_comb begin
        raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        cout = (raw > 5'd9);
        sum  = cout ? raw[3:0] + 4'd6 : raw[3:0];
    end

endmodule

// File: rtl/scmp_acc_sr.sv
// SC/MP AC, E and status register with optional two-cycle decimal add.
// Define SCMP_DAD_EN to build the DAD state machine.
module scmp_acc_sr
    import scmp_microcode_pak::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] alu_res,
    input  logic       alu_cy,
    input  logic       alu_ov,
    input  logic       ld_ac,
    input  logic       ld_e,
    input  logic       ld_sr,
    input  logic       ld_cy,
    input  logic       ld_ov,
    input  logic       xae,
    input  logic       sio,
    input  logic       sin_i,
    input  logic       sa_i,
    input  logic       sb_i,
    input  logic       dad_start,
    input  logic [7:0] dad_b,
    output logic [7:0] ac_o,
    output logic [7:0] e_o,
    output logic [7:0] sr_o,
    output logic       cy_o,
    output logic       ov_o,
    output logic       ie_o,
    output logic [2:0] flags_o,
    output logic       sout_o,
    output logic       busy_o
);

    logic [7:0] ac;
    logic [7:0] e;
    logic       cy;
    logic       ov;
    logic       ie;
    logic [2:0] flags;
    logic [1:0] sa_sync;
    logic [1:0] sb_sync;
    logic       busy;
    logic       dad_done;
    logic [7:0] dad_res;
    logic       dad_cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_sync <= '0;
            sb_sync <= '0;
        end else begin
            sa_sync <= {sa_sync[0], sa_i};
            sb_sync <= {sb_sync[0], sb_i};
        end
    end

    // DAD writeback owns AC/CY on its last cycle; busy freezes everything else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac    <= '0;
            e     <= '0;
            cy    <= 1'b0;
            ov    <= 1'b0;
            ie    <= 1'b0;
            flags <= '0;
        end else if (dad_done) begin
            ac <= dad_res;
            cy <= dad_cy;
        end else if (!busy) begin
            if (xae) begin
                ac <= e;
                e  <= ac;
            end else begin
                if (ld_ac)
                    ac <= alu_res;
                if (sio)
                    e <= {sin_i, e[7:1]};
                else if (ld_e)
                    e <= alu_res;
            end
            if (ld_cy)
                cy <= alu_cy;
            else if (ld_sr)
                cy <= alu_res[SR_CY];
            if (ld_ov)
                ov <= alu_ov;
            else if (ld_sr)
                ov <= alu_res[SR_OV];
            if (ld_sr) begin
                ie    <= alu_res[SR_IE];
                flags <= alu_res[SR_F2:SR_F0];
            end
        end
    end

`ifdef SCMP_DAD_EN
    dad_state_t state;
    dad_state_t state_nx;
    logic [7:0] lat_a;
    logic [7:0] lat_b;
    logic       lat_c;
    logic [3:0] lo_sum;
    logic       dc;
    logic [3:0] dg_a;
    logic [3:0] dg_b;
    logic       dg_cin;
    logic [3:0] dg_sum;
    logic       dg_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // One digit adder serves both cycles: low nibble in LO, high in HI
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        dad_done = 1'b0;
        dg_a     = lat_a[3:0];
        dg_b     = lat_b[3:0];
        dg_cin   = lat_c;
        unique case (state)
            IDLE: begin
                if (dad_start)
                    state_nx = LO;
            end
            LO: begin
                busy     = 1'b1;
                state_nx = HI;
            end
            HI: begin
                busy     = 1'b1;
                dad_done = 1'b1;
                dg_a     = lat_a[7:4];
                dg_b     = lat_b[7:4];
                dg_cin   = dc;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a  <= '0;
            lat_b  <= '0;
            lat_c  <= 1'b0;
            lo_sum <= '0;
            dc     <= 1'b0;
        end else if (state == IDLE && dad_start) begin
            lat_a <= ac;
            lat_b <= dad_b;
            lat_c <= cy;
        end else if (state == LO) begin
            lo_sum <= dg_sum;
            dc     <= dg_cout;
        end
    end

    scmp_bcd_digit u_digit (
        .a    (dg_a),
        .b    (dg_b),
        .cin  (dg_cin),
        .sum  (dg_sum),
        .cout (dg_cout)
    );

    assign dad_res = {dg_sum, lo_sum};
    assign dad_cy  = dg_cout;
`else
    logic dad_unused;

    assign busy       = 1'b0;
    assign dad_done   = 1'b0;
    assign dad_res    = '0;
    assign dad_cy     = 1'b0;
    assign dad_unused = ^{dad_start, dad_b};
`endif

    always_comb begin
        sr_o                = '0;
        sr_o[SR_CY]         = cy;
        sr_o[SR_OV]         = ov;
        sr_o[SR_SB]         = sb_sync[1];
        sr_o[SR_SA]         = sa_sync[1];
        sr_o[SR_IE]         = ie;
        sr_o[SR_F2:SR_F0]   = flags;
    end

    assign ac_o    = ac;
    assign e_o     = e;
    assign cy_o    = cy;
    assign ov_o    = ov;
    assign ie_o    = ie;
    assign flags_o = flags;
    assign sout_o  = e[0];
    assign busy_o  = busy;

endmodule

// File: tb/tb_scmp_acc_sr.sv
// Bench for scmp_acc_sr: directed cases plus random traffic vs a model.
// DAD-specific expectations follow SCMP_DAD_EN.
module tb_scmp_acc_sr;

    logic       clk;
    logic       rst_n;
    logic [7:0] alu_res;
    logic       alu_cy, alu_ov;
    logic       ld_ac, ld_e, ld_sr, ld_cy, ld_ov;
    logic       xae, sio, sin_i, sa_i, sb_i;
    logic       dad_start;
    logic [7:0] dad_b;
    logic [7:0] ac_o, e_o, sr_o;
    logic       cy_o, ov_o, ie_o, sout_o, busy_o;
    logic [2:0] flags_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_ac, m_e;
    logic       m_cy, m_ov, m_ie;
    logic [2:0] m_f;
    logic [8:0] m_res;
    int         m_cnt;
    logic       sa_q[$];
    logic       sb_q[$];

    scmp_acc_sr dut (
        .clk(clk), .rst_n(rst_n), .alu_res(alu_res),
        .alu_cy(alu_cy), .alu_ov(alu_ov),
        .ld_ac(ld_ac), .ld_e(ld_e), .ld_sr(ld_sr),
        .ld_cy(ld_cy), .ld_ov(ld_ov), .xae(xae), .sio(sio),
        .sin_i(sin_i), .sa_i(sa_i), .sb_i(sb_i),
        .dad_start(dad_start), .dad_b(dad_b),
        .ac_o(ac_o), .e_o(e_o), .sr_o(sr_o), .cy_o(cy_o),
        .ov_o(ov_o), .ie_o(ie_o), .flags_o(flags_o),
        .sout_o(sout_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_bcd(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Valid BCD: ordinary decimal sum. Otherwise the digit-wise +6 rule.
    function automatic logic [8:0] dad_ref(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic c);
        int s, lo, hi, dc, hc;
        logic [8:0] r;
        if (is_bcd(a) && is_bcd(b)) begin
            s = 10 * int'(a[7:4]) + int'(a[3:0])
              + 10 * int'(b[7:4]) + int'(b[3:0]) + int'(c);
            r[8]   = (s >= 100);
            r[7:4] = 4'((s % 100) / 10);
            r[3:0] = 4'(s % 10);
        end else begin
            lo = int'(a[3:0]) + int'(b[3:0]) + int'(c);
            dc = (lo > 9) ? 1 : 0;
            lo = lo + 6 * dc;
            hi = int'(a[7:4]) + int'(b[7:4]) + dc;
            hc = (hi > 9) ? 1 : 0;
            hi = hi + 6 * hc;
            r  = {hc[0], 4'(hi), 4'(lo)};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ac"}, ac_o, m_ac);
        chk({tag, ".e"}, e_o, m_e);
        chk({tag, ".sr"}, sr_o,
            {m_cy, m_ov, sb_q[0], sa_q[0], m_ie, m_f});
        chk({tag, ".misc"}, {cy_o, ov_o, ie_o, flags_o, sout_o, busy_o},
            {m_cy, m_ov, m_ie, m_f, m_e[0], m_cnt != 0});
    endtask

    task automatic model_reset();
        m_ac = '0; m_e = '0; m_cy = 0; m_ov = 0; m_ie = 0; m_f = '0;
        m_res = '0; m_cnt = 0;
        sa_q = '{1'b0, 1'b0};
        sb_q = '{1'b0, 1'b0};
    endtask

    task automatic clr();
        alu_res = '0; alu_cy = 0; alu_ov = 0;
        ld_ac = 0; ld_e = 0; ld_sr = 0; ld_cy = 0; ld_ov = 0;
        xae = 0; sio = 0; sin_i = 0; sa_i = 0; sb_i = 0;
        dad_start = 0; dad_b = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst.ac", ac_o, 8'h00);
        chk("rst.e", e_o, 8'h00);
        chk("rst.sr", sr_o, 8'h00);
        chk("rst.misc", {cy_o, ov_o, ie_o, flags_o, sout_o, busy_o}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Advance the model across one edge, clock the DUT, compare everything.
    task automatic step(input string tag = "step");
        logic [7:0] n_ac, n_e;
        logic       n_cy, n_ov;
        n_ac = m_ac; n_e = m_e; n_cy = m_cy; n_ov = m_ov;
        if (m_cnt != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                n_ac = m_res[7:0];
                n_cy = m_res[8];
            end
        end else begin
            if (xae) begin
                n_ac = m_e;
                n_e  = m_ac;
            end else begin
                if (ld_ac) n_ac = alu_res;
                if (sio) n_e = {sin_i, m_e[7:1]};
                else if (ld_e) n_e = alu_res;
            end
            if (ld_sr) begin
                n_cy = alu_res[7]; n_ov = alu_res[6];
                m_ie = alu_res[3]; m_f = alu_res[2:0];
            end
            if (ld_cy) n_cy = alu_cy;
            if (ld_ov) n_ov = alu_ov;
`ifdef SCMP_DAD_EN
            if (dad_start) begin
                m_res = dad_ref(m_ac, dad_b, m_cy);
                m_cnt = 2;
            end
`endif
        end
        sa_q.push_back(sa_i); void'(sa_q.pop_front());
        sb_q.push_back(sb_i); void'(sb_q.pop_front());
        m_ac = n_ac; m_e = n_e; m_cy = n_cy; m_ov = n_ov;
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        clr();
        model_reset();
        do_reset();

        // 45 + 38 + 0 with OV preset to 1
        alu_res = 8'h45; ld_ac = 1; ld_cy = 1; alu_cy = 0;
        ld_ov = 1; alu_ov = 1;
        step("ld45"); clr();
        dad_b = 8'h38; dad_start = 1;
        step("dad1.s"); clr();
`ifdef SCMP_DAD_EN
        chk("dad1.busy_a", {7'b0, busy_o}, 8'h01);
`endif
        step("dad1.lo");
`ifdef SCMP_DAD_EN
        chk("dad1.busy_b", {7'b0, busy_o}, 8'h01);
`endif
        step("dad1.hi");
`ifdef SCMP_DAD_EN
        chk("dad1.ac", ac_o, 8'h83);
`else
        chk("nodad1.ac", ac_o, 8'h45);
`endif
        chk("dad1.cyov", {6'b0, cy_o, ov_o}, 8'h01);
        chk("dad1.idle", {7'b0, busy_o}, 8'h00);

        // 99 + 00 + 1, with an ld_ac arriving while busy
        alu_res = 8'h99; ld_ac = 1; ld_cy = 1; alu_cy = 1;
        step("ld99"); clr();
        dad_b = 8'h00; dad_start = 1;
        step("dad2.s"); clr();
        alu_res = 8'h11; ld_ac = 1;
        step("dad2.lo"); clr();
        step("dad2.hi");
`ifdef SCMP_DAD_EN
        chk("dad2.ac", ac_o, 8'h00);
        chk("dad2.cy", {7'b0, cy_o}, 8'h01);
`else
        chk("nodad2.ac", ac_o, 8'h11);
`endif

        // Non-BCD operands: FF + FF + 1 adjusts to 55, carry out
        alu_res = 8'hFF; ld_ac = 1; ld_cy = 1; alu_cy = 1;
        step("ldff"); clr();
        dad_b = 8'hFF; dad_start = 1;
        step("dad3.s"); clr();
        step("dad3.lo");
        step("dad3.hi");
`ifdef SCMP_DAD_EN
        chk("dad3.ac", ac_o, 8'h55);
        chk("dad3.cy", {7'b0, cy_o}, 8'h01);
`endif

        // XAE beats ld_ac
        alu_res = 8'h12; ld_ac = 1; step("ld12"); clr();
        alu_res = 8'h34; ld_e = 1; step("ld34"); clr();
        alu_res = 8'hAA; ld_ac = 1; xae = 1; step("xae"); clr();
        chk("xae.ac", ac_o, 8'h34);
        chk("xae.e", e_o, 8'h12);

        // Serial shift of E
        alu_res = 8'h81; ld_e = 1; step("ld81"); clr();
        chk("sio.sout0", {7'b0, sout_o}, 8'h01);
        sio = 1; sin_i = 1; step("sio1");
        chk("sio.sout1", {7'b0, sout_o}, 8'h00);
        step("sio2"); clr();
        chk("sio.e", e_o, 8'hE0);

        // SR write with CY override, then SA synchroniser delay
        alu_res = 8'hFF; ld_sr = 1; ld_cy = 1; alu_cy = 0;
        step("ldsr"); clr();
        chk("sr.val", sr_o, 8'h4F);
        sa_i = 1;
        step("sa1");
        chk("sa.edge1", {7'b0, sr_o[4]}, 8'h00);
        step("sa2");
        chk("sa.edge2", {7'b0, sr_o[4]}, 8'h01);
        clr();
        step("sa3");

        // Reset in the middle of an add, then a clean add
        alu_res = 8'h27; ld_ac = 1; step("ld27"); clr();
        dad_b = 8'h15; dad_start = 1; step("dad4.s"); clr();
        do_reset();
        alu_res = 8'h45; ld_ac = 1; step("ld45b"); clr();
        dad_b = 8'h38; dad_start = 1; step("dad5.s"); clr();
        step("dad5.lo");
        step("dad5.hi");
`ifdef SCMP_DAD_EN
        chk("dad5.ac", ac_o, 8'h83);
`endif

        for (int i = 0; i < 400; i++) begin
            alu_res   = 8'($urandom);
            alu_cy    = 1'($urandom);
            alu_ov    = 1'($urandom);
            ld_ac     = ($urandom_range(0, 3) == 0);
            ld_e      = ($urandom_range(0, 3) == 0);
            ld_sr     = ($urandom_range(0, 5) == 0);
            ld_cy     = ($urandom_range(0, 4) == 0);
            ld_ov     = ($urandom_range(0, 4) == 0);
            xae       = ($urandom_range(0, 7) == 0);
            sio       = ($urandom_range(0, 5) == 0);
            sin_i     = 1'($urandom);
            sa_i      = 1'($urandom);
            sb_i      = 1'($urandom);
            dad_start = ($urandom_range(0, 5) == 0);
            dad_b     = 8'($urandom);
            step("rnd");
        end
        clr();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
